power_arbiter: RTL and testbench

- Round-robin scheduler that shares one squaring multiplier and one adder between NUM_CH complex-sample requesters.
- Each accepted sample (real, imag) is sequenced through the shared datapath in two multiply steps: real², then imag² plus accumulate.
- Produces one power result, real² + imag², tagged with the source channel.
- Sits between the per-channel front ends and the downstream 10log10 (dB) conversion stage, replacing one power engine per channel.

---
 rtl/power_pkg.sv | 28 ++
 rtl/power_mac.sv | 34 +++
 rtl/power_arbiter.sv | 116 +++++++++++
 tb/tb_power_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_pkg.sv
// rtl/power_pkg.sv - shared state type, default sizes and round-robin search for power_arbiter
package power_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_IN_WIDTH = 16;
  localparam int MAX_CH       = 32;

  typedef enum logic [1:0] {IDLE, MUL_RE, MUL_IM, HOLD} state_t;

  // First set bit of req at or above ptr, wrapping at n; returns ptr when req is empty.
  function automatic logic [4:0] rr_first(input logic [MAX_CH-1:0] req,
                                          input logic [4:0]        ptr,
                                          input logic [5:0]        n);
    logic [5:0] idx;
    logic       found;
    rr_first = ptr;
    found    = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      idx = {1'b0, ptr} + 6'(i);
      if (idx >= n) idx = idx - n;
      if ((6'(i) < n) && !found && req[idx[4:0]]) begin
        rr_first = idx[4:0];
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/power_mac.sv
// rtl/power_mac.sv - shared squaring multiplier, adder and accumulator for power_arbiter
module power_mac
  import power_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load,
  input  logic                        i_accum,
  input  logic signed [IN_WIDTH-1:0]  i_a,
  output logic [2*IN_WIDTH-1:0]       o_sum
);

  logic signed [2*IN_WIDTH-1:0] w_a_ext;
  logic signed [2*IN_WIDTH-1:0] w_sq;
  logic [2*IN_WIDTH-1:0]        r_acc;

  // Sign-extend first so the truncated product is exact; a*a is never negative.
  assign w_a_ext = {{IN_WIDTH{i_a[IN_WIDTH-1]}}, i_a};
  assign w_sq    = w_a_ext * w_a_ext;
  assign o_sum   = r_acc + $unsigned(w_sq);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= $unsigned(w_sq);
    end else if (i_accum) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/power_arbiter.sv
// rtl/power_arbiter.sv - round-robin scheduler sharing one power engine across NUM_CH requesters
module power_arbiter
  import power_pkg::*;
#(
  parameter  int NUM_CH   = DEF_NUM_CH,
  parameter  int IN_WIDTH = DEF_IN_WIDTH,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*IN_WIDTH-1:0]   in_real,
  input  logic [NUM_CH*IN_WIDTH-1:0]   in_imag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*IN_WIDTH-1:0]        out_power,
  output logic [CH_W-1:0]              out_ch
);

  state_t                      r_state;
  state_t                      w_next;
  logic [CH_W-1:0]             r_rr_ptr;
  logic [CH_W-1:0]             r_ch;
  logic [CH_W-1:0]             r_out_ch;
  logic [CH_W-1:0]             w_grant;
  logic [4:0]                  w_pick;
  logic signed [IN_WIDTH-1:0]  r_re;
  logic signed [IN_WIDTH-1:0]  r_im;
  logic signed [IN_WIDTH-1:0]  w_mac_a;
  logic [2*IN_WIDTH-1:0]       r_out_power;
  logic [2*IN_WIDTH-1:0]       w_sum;
  logic                        r_out_valid;
  logic                        w_any;
  logic                        w_take;

  assign w_any   = |in_valid;
  assign w_pick  = rr_first(MAX_CH'(in_valid), 5'(r_rr_ptr), 6'(NUM_CH));
  assign w_grant = w_pick[CH_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = '0;
    w_take   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          in_ready[w_grant] = 1'b1;
          w_take            = 1'b1;
          w_next            = MUL_RE;
        end
      end
      MUL_RE:  w_next = MUL_IM;
      MUL_IM:  w_next = HOLD;
      HOLD: begin
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Real part is squared first, then the imaginary square is added to it.
  assign w_mac_a = (r_state == MUL_RE) ? r_re : r_im;

  power_mac #(
    .IN_WIDTH (IN_WIDTH)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_load  (r_state == MUL_RE),
    .i_accum (r_state == MUL_IM),
    .i_a     (w_mac_a),
    .o_sum   (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_ch        <= '0;
      r_re        <= '0;
      r_im        <= '0;
      r_out_power <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_take) begin
        r_re     <= in_real[w_grant*IN_WIDTH +: IN_WIDTH];
        r_im     <= in_imag[w_grant*IN_WIDTH +: IN_WIDTH];
        r_ch     <= w_grant;
        r_rr_ptr <= (w_grant == CH_W'(NUM_CH-1)) ? '0 : w_grant + CH_W'(1);
      end
      if (r_state == MUL_IM) begin
        r_out_power <= w_sum;
        r_out_ch    <= r_ch;
        r_out_valid <= 1'b1;
      end
      if ((r_state == HOLD) && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_power <= '0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_power = r_out_power;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_power_arbiter.sv
// tb/tb_power_arbiter.sv - scoreboard bench for power_arbiter: directed cases plus randomized traffic
`timescale 1ns/1ps
module tb_power_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [N*W-1:0]   in_real;
  logic [N*W-1:0]   in_imag;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_power;
  logic [CW-1:0]    out_ch;

  always #5 clk = ~clk;

  power_arbiter #(.NUM_CH(N), .IN_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_power (out_power),
    .out_ch    (out_ch)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected results in grant order, pointer, and cycles since grant.
  typedef struct {
    int     ch;
    longint pwr;
  } res_t;

  res_t   exp_q[$];
  int     m_ptr = 0;
  int     m_age = 0;
  bit     m_busy = 1'b0;
  int     grant_cnt = 0;
  int     result_cnt = 0;
  int     grant_log[$];
  longint res_pwr[$];
  int     res_ch[$];

  bit           mon_ov;
  int           mon_g;
  int           mon_dg;
  logic [N-1:0] mon_rdy;

  function automatic int rr_model(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic longint comp(input logic [N*W-1:0] bus, input int c);
    logic signed [W-1:0] x;
    x = bus[c*W +: W];
    return longint'(x);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_ptr  = 0;
      m_age  = 0;
    end else begin
      mon_ov = m_busy && (m_age >= 3);
      check("out_valid", out_valid, mon_ov);
      mon_g   = m_busy ? -1 : rr_model(in_valid, m_ptr);
      mon_rdy = '0;
      if (mon_g >= 0) mon_rdy[mon_g] = 1'b1;
      check("in_ready", in_ready, mon_rdy);
      if (mon_ov) begin
        if (exp_q.size() == 0) begin
          check("queue_nonempty", 0, 1);
        end else begin
          check("out_power", out_power, exp_q[0].pwr);
          check("out_ch", out_ch, exp_q[0].ch);
        end
      end else begin
        check("out_power_idle", out_power, 0);
      end
      if (m_busy) begin
        if (mon_ov && out_ready) begin
          res_pwr.push_back(longint'(out_power));
          res_ch.push_back(int'(out_ch));
          result_cnt++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end else if (mon_g >= 0) begin
        exp_q.push_back('{mon_g, comp(in_real, mon_g) * comp(in_real, mon_g)
                                 + comp(in_imag, mon_g) * comp(in_imag, mon_g)});
        mon_dg = -1;
        for (int k = 0; k < N; k++) if (in_ready[k] && in_valid[k]) mon_dg = k;
        grant_log.push_back(mon_dg);
        m_ptr  = (mon_g + 1) % N;
        m_busy = 1'b1;
        m_age  = 1;
        grant_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input int re, input int im);
    in_real[c*W +: W] = W'(re);
    in_imag[c*W +: W] = W'(im);
  endtask

  task automatic wait_grants(input int target, input int budget);
    int t;
    t = 0;
    while (grant_cnt < target && t < budget) begin
      step();
      t++;
    end
    if (grant_cnt < target) check("grant_timeout", grant_cnt, target);
  endtask

  task automatic wait_results(input int target, input int budget);
    int t;
    t = 0;
    while (result_cnt < target && t < budget) begin
      step();
      t++;
    end
    if (result_cnt < target) check("result_timeout", result_cnt, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int exp_g3[5] = '{0, 1, 2, 3, 0};
  int exp_p3[5] = '{1, 4, 9, 16, 1};
  int exp_g4[3] = '{1, 2, 0};
  int gb;
  int rb;
  int t;
  int r;

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_real   = '0;
    in_imag   = '0;
    out_ready = 1'b1;
    step();
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_power", out_power, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_in_ready", in_ready, 0);

    // ch0 alone: 3,4 -> 25
    gb = grant_cnt; rb = result_cnt;
    set_ch(0, 3, 4);
    in_valid = 4'b0001;
    wait_grants(gb + 1, 10);
    in_valid = '0;
    wait_results(rb + 1, 20);
    check("p1_grant", grant_log[gb], 0);
    check("p1_power", res_pwr[rb], 25);
    check("p1_ch", res_ch[rb], 0);

    // ch1 most-negative corner
    gb = grant_cnt; rb = result_cnt;
    set_ch(1, -32768, -32768);
    in_valid = 4'b0010;
    wait_grants(gb + 1, 10);
    in_valid = '0;
    wait_results(rb + 1, 20);
    check("p2_power", res_pwr[rb], 64'h8000_0000);
    check("p2_ch", res_ch[rb], 1);

    // all channels requesting from rr_ptr=0
    do_reset();
    gb = grant_cnt; rb = result_cnt;
    for (int k = 0; k < N; k++) set_ch(k, k + 1, 0);
    in_valid = 4'b1111;
    wait_grants(gb + 5, 40);
    in_valid = '0;
    wait_results(rb + 5, 40);
    for (int i = 0; i < 5; i++) begin
      check("p3_grant", grant_log[gb + i], exp_g3[i]);
      check("p3_power", res_pwr[rb + i], exp_p3[i]);
    end

    // grant ch1, then ch0+ch2 -> ch2 before ch0
    do_reset();
    gb = grant_cnt; rb = result_cnt;
    set_ch(1, 2, 2);
    in_valid = 4'b0010;
    wait_grants(gb + 1, 10);
    set_ch(0, 1, 1);
    set_ch(2, 3, 3);
    in_valid = 4'b0101;
    wait_grants(gb + 3, 40);
    in_valid = '0;
    wait_results(rb + 3, 40);
    for (int i = 0; i < 3; i++) check("p4_grant", grant_log[gb + i], exp_g4[i]);

    // backpressure in HOLD, then immediate regrant after release
    gb = grant_cnt; rb = result_cnt;
    set_ch(0, 5, 12);
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    wait_grants(gb + 1, 10);
    set_ch(1, 1, 0);
    in_valid = 4'b0010;
    t = 0;
    while (!out_valid && t < 10) begin
      step();
      t++;
    end
    check("p5_out_valid_rise", out_valid, 1);
    repeat (5) step();
    check("p5_still_held", result_cnt, rb);
    out_ready = 1'b1;
    step();
    step();
    check("p5_regrant_next_cycle", grant_cnt, gb + 2);
    in_valid = '0;
    wait_results(rb + 2, 20);
    check("p5_power", res_pwr[rb], 169);
    check("p5_ch", res_ch[rb], 0);

    // reset while in MUL_IM drops the sample and rr_ptr
    set_ch(2, 7, 7);
    in_valid = 4'b0100;
    gb = grant_cnt;
    wait_grants(gb + 1, 10);
    in_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("p6_out_valid", out_valid, 0);
    check("p6_out_power", out_power, 0);
    gb = grant_cnt; rb = result_cnt;
    set_ch(0, 6, 0);
    set_ch(3, 9, 9);
    in_valid = 4'b1001;
    wait_grants(gb + 1, 10);
    in_valid = '0;
    wait_results(rb + 1, 20);
    check("p6_grant", grant_log[gb], 0);
    check("p6_power", res_pwr[rb], 36);
    check("p6_ch", res_ch[rb], 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 999) == 0);
      in_valid = N'($urandom);
      for (int k = 0; k < N; k++) begin
        r = $urandom_range(0, 9);
        in_real[k*W +: W] = (r == 0) ? 16'h8000 : (r == 1) ? 16'h7fff : W'($urandom);
        r = $urandom_range(0, 9);
        in_imag[k*W +: W] = (r == 0) ? 16'h8000 : (r == 1) ? 16'h7fff : W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst       = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (10) step();
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
